// File: rtl/crc7_serial.sv
// ---------------------------------------------------------------------------
// crc7_serial
//
// Bit-serial CRC7 generator for eMMC/SD command frames. Polynomial
// x^7 + x^3 + 1 (0x09), initial value 0, payload shifted in MSB first.
//
// The block runs a fixed, free-running frame cycle after reset:
//   DATA : absorb DATA_BITS payload bits from data_in into crc_reg
//   TAIL : shift out crc_out[6..0] followed by a '1' end bit on crc_ser
// and then returns to DATA with a cleared CRC register. No handshake
// inputs exist; the upstream command serializer must keep step with it.
//
// Parameters
//   DATA_BITS  payload bits per frame, legal range 1..255 (default 40)
//
// Ports
//   clk        in   1  rising-edge clock
//   rstn       in   1  synchronous reset, ACTIVE-HIGH despite the name
//   data_in    in   1  serial payload bit, sampled only in the DATA phase
//   crc_reg    out  7  running CRC register
//   crc_out    out  7  CRC latched on the last payload bit, held until next
//   crc_valid  out  1  one-cycle pulse while crc_out holds a fresh value
//   crc_ser    out  1  serial tail (CRC MSB first, then end bit), idle high
//   ser_en     out  1  high while crc_ser carries the 8 tail bits
//   bit_cnt    out  8  position inside the current phase
//   busy_data  out  1  high during the DATA phase
// ---------------------------------------------------------------------------
module crc7_serial #(
  parameter int unsigned DATA_BITS = 40
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       data_in,
  output logic [6:0] crc_reg,
  output logic [6:0] crc_out,
  output logic       crc_valid,
  output logic       crc_ser,
  output logic       ser_en,
  output logic [7:0] bit_cnt,
  output logic       busy_data
);

  typedef enum logic {
    PH_DATA = 1'b0,
    PH_TAIL = 1'b1
  } phase_e;

  // Last counter value in each phase; the tail is 7 CRC bits + 1 end bit.
  localparam logic [7:0] LP_DATA_LAST = 8'(DATA_BITS - 1);
  localparam logic [7:0] LP_TAIL_LAST = 8'd7;

  phase_e     r_phase;
  phase_e     w_phase_nxt;
  logic [7:0] r_bit_cnt;
  logic [7:0] w_bit_cnt_nxt;
  logic [6:0] r_crc;
  logic [6:0] w_crc_nxt;
  logic [6:0] r_crc_out;
  logic [6:0] w_crc_out_nxt;
  logic       r_valid;
  logic       w_valid_nxt;

  logic       w_fb;
  logic [6:0] w_crc_step;
  logic [7:0] w_tail_word;

  // One CRC step: shift left and fold the polynomial in at bits 3 and 0
  // whenever the feedback (incoming bit XOR outgoing MSB) is set.
  assign w_fb       = data_in ^ r_crc[6];
  assign w_crc_step = {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};

  // State register. Reset wins over everything, so a partial frame or a
  // partially transmitted tail is simply discarded.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_phase   <= PH_DATA;
      r_bit_cnt <= 8'd0;
      r_crc     <= 7'd0;
      r_crc_out <= 7'd0;
      r_valid   <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_crc     <= w_crc_nxt;
      r_crc_out <= w_crc_out_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  // Next-state logic. Everything holds by default; DATA advances the CRC
  // and hands the final value to crc_out on the last payload bit, TAIL
  // only counts and clears the CRC when it hands back to DATA.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_bit_cnt_nxt = r_bit_cnt;
    w_crc_nxt     = r_crc;
    w_crc_out_nxt = r_crc_out;
    w_valid_nxt   = 1'b0;

    case (r_phase)
      PH_DATA: begin
        w_crc_nxt = w_crc_step;
        if (r_bit_cnt == LP_DATA_LAST) begin
          w_phase_nxt   = PH_TAIL;
          w_bit_cnt_nxt = 8'd0;
          w_crc_out_nxt = w_crc_step;
          w_valid_nxt   = 1'b1;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
        end
      end

      PH_TAIL: begin
        if (r_bit_cnt == LP_TAIL_LAST) begin
          w_phase_nxt   = PH_DATA;
          w_bit_cnt_nxt = 8'd0;
          w_crc_nxt     = 7'd0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
        end
      end

      default: begin
        w_phase_nxt   = PH_DATA;
        w_bit_cnt_nxt = 8'd0;
        w_crc_nxt     = 7'd0;
      end
    endcase
  end

  // The tail word is the latched CRC with the end bit appended; shifting it
  // left by the tail position puts the bit to transmit in the MSB, so
  // position 7 naturally yields the '1' end bit.
  assign w_tail_word = {r_crc_out, 1'b1} << r_bit_cnt[2:0];

  assign crc_ser   = (r_phase == PH_TAIL) ? w_tail_word[7] : 1'b1;
  assign ser_en    = (r_phase == PH_TAIL);
  assign busy_data = (r_phase == PH_DATA);
  assign crc_reg   = r_crc;
  assign crc_out   = r_crc_out;
  assign crc_valid = r_valid;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_crc7_serial.sv
// ---------------------------------------------------------------------------
// tb_crc7_serial
//
// Self-checking bench for crc7_serial with DATA_BITS = 40. Known command
// frames and random frames are applied back-to-back from a vector table;
// the expected CRC of each frame is queued when the frame starts and popped
// by a monitor when crc_valid fires. Hand-written sequences cover reset in
// the middle of a payload and in the middle of the serial tail.
// ---------------------------------------------------------------------------
module tb_crc7_serial;

  localparam int DataBits = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dataIn = 1'b0;
  logic [6:0] crcReg;
  logic [6:0] crcOut;
  logic       crcValid;
  logic       crcSer;
  logic       serEn;
  logic [7:0] bitCnt;
  logic       busyData;

  int compared = 0;
  int mismatched = 0;
  int validPulses = 0;
  int pushes = 0;
  logic [6:0] expectQ[$];

  typedef struct {
    logic [39:0] payload;
    logic [6:0]  expCrc;
    bit          has8;
    logic [6:0]  expCrc8;
  } vector_t;

  vector_t vectors[6];

  crc7_serial #(.DATA_BITS(DataBits)) dut (
    .clk       (clock),
    .rstn      (reset),
    .data_in   (dataIn),
    .crc_reg   (crcReg),
    .crc_out   (crcOut),
    .crc_valid (crcValid),
    .crc_ser   (crcSer),
    .ser_en    (serEn),
    .bit_cnt   (bitCnt),
    .busy_data (busyData)
  );

  // Free-running clock; inputs change and outputs are sampled on negedge.
  always #5 clock = ~clock;

  // Reference CRC: polynomial long division one bit at a time.
  function automatic logic [6:0] crcStep(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crcModel(input logic [39:0] payload);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crcStep(c, payload[i]);
    return c;
  endfunction

  // Single comparison point: every check, pass or fail, goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every crc_valid pulse must match the oldest queued CRC.
  always @(negedge clock) begin
    if (crcValid === 1'b1) begin
      validPulses++;
      if (expectQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedValid: got crc_valid=1 crc_out=0x%0h, expected no pulse at %0t",
                 crcOut, $time);
      end else begin
        checkOutput("crcOutAtValid", crcOut, expectQ.pop_front());
      end
    end
  end

  task automatic checkReset();
    checkOutput("rstCrcReg", crcReg, 0);
    checkOutput("rstCrcOut", crcOut, 0);
    checkOutput("rstCrcValid", crcValid, 0);
    checkOutput("rstCrcSer", crcSer, 1);
    checkOutput("rstSerEn", serEn, 0);
    checkOutput("rstBitCnt", bitCnt, 0);
    checkOutput("rstBusyData", busyData, 1);
  endtask

  // Hold reset with random data on the line and confirm the reset state.
  task automatic applyReset(input int cycles);
    @(negedge clock);
    reset  = 1'b1;
    dataIn = 1'($urandom);
    repeat (cycles) begin
      @(negedge clock);
      checkReset();
      dataIn = 1'($urandom);
    end
  endtask

  // Drive nBits payload bits (a full frame when nBits == DataBits) and then
  // check the tail. abortAt >= 0 raises reset at that tail position.
  task automatic applyStimulus(input logic [39:0] payload, input logic [6:0] expCrc,
                               input bit has8, input logic [6:0] exp8,
                               input int nBits, input int abortAt);
    logic [6:0] model;
    model = 7'd0;
    if (nBits == DataBits) begin
      expectQ.push_back(expCrc);
      pushes++;
    end
    for (int n = 0; n < nBits; n++) begin
      @(negedge clock);
      checkOutput("crcRegRunning", crcReg, model);
      checkOutput("bitCntData", bitCnt, n);
      checkOutput("busyDataHigh", busyData, 1);
      checkOutput("serEnIdle", serEn, 0);
      checkOutput("crcSerIdle", crcSer, 1);
      if (has8 && n == 8) checkOutput("crcRegAfter8", crcReg, exp8);
      reset  = 1'b0;
      dataIn = payload[39 - n];
      model  = crcStep(model, dataIn);
    end
    if (nBits == DataBits) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        checkOutput("serEnTail", serEn, 1);
        checkOutput("busyDataTail", busyData, 0);
        checkOutput("bitCntTail", bitCnt, k);
        checkOutput("crcSerTail", crcSer, (k < 7) ? expCrc[6 - k] : 1'b1);
        checkOutput("crcValidTail", crcValid, (k == 0) ? 1 : 0);
        checkOutput("crcRegHeld", crcReg, model);
        checkOutput("crcOutHeld", crcOut, expCrc);
        dataIn = 1'($urandom);
        if (k == abortAt) begin
          reset = 1'b1;
          break;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] rnd;

    vectors[0] = '{40'h40_0000_0000, 7'h4A, 1'b0, 7'h00};
    vectors[1] = '{40'h51_0000_0000, 7'h2A, 1'b0, 7'h00};
    vectors[2] = '{40'h48_0000_01AA, 7'h43, 1'b0, 7'h00};
    vectors[3] = '{40'hA1_0000_0000, crcModel(40'hA1_0000_0000), 1'b1, 7'h7A};
    for (int v = 4; v < 6; v++) begin
      rnd = {$urandom, $urandom};
      vectors[v] = '{rnd[39:0], crcModel(rnd[39:0]), 1'b0, 7'h00};
    end

    $display("[TB] reset hold");
    applyReset(3);

    $display("[TB] back-to-back vector frames");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vectors[v].payload, vectors[v].expCrc, vectors[v].has8,
                    vectors[v].expCrc8, DataBits, -1);
    end

    $display("[TB] reset after 20 payload bits, then CMD0");
    applyStimulus(40'h5A_A5C3_3C0F, 7'h00, 1'b0, 7'h00, 20, -1);
    applyReset(1);
    applyStimulus(40'h40_0000_0000, 7'h4A, 1'b0, 7'h00, DataBits, -1);

    $display("[TB] reset at tail bit 3");
    applyStimulus(40'h51_0000_0000, 7'h2A, 1'b0, 7'h00, DataBits, 3);
    @(negedge clock);
    checkReset();
    applyStimulus(40'h40_0000_0000, 7'h4A, 1'b0, 7'h00, DataBits, -1);

    repeat (2) @(negedge clock);
    checkOutput("queueDrained", expectQ.size(), 0);
    checkOutput("validPulseCount", validPulses, pushes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
